// File: rtl/init_reset_sequencer.sv
// Init/reset sequencer: synchronises device init-monitor flags, waits for them to be stable,
// then releases peripheral reset followed by CPU reset, and re-enters reset on any dropout.
module init_reset_sequencer #(
   parameter int SYNC_STAGES        = 2,
   parameter int STABLE_CYCLES      = 16,
   parameter int STAGE_DELAY        = 8,
   parameter int TIMEOUT_CYCLES     = 1000000,
   parameter int REQUIRE_BANK_CALIB = 1
) (
   input  logic       CLK,
   input  logic       RESETN,
   input  logic       FABRIC_POR_N,
   input  logic       DEVICE_INIT_DONE,
   input  logic       BANK_1_CALIB_STATUS,
   input  logic       PLL_LOCK,
   output logic       PERIPH_RESET_N,
   output logic       CPU_RESET_N,
   output logic       INIT_FAULT,
   output logic [1:0] STATE
);

   typedef enum logic [1:0] {
      WAIT_READY = 2'd0,
      REL_PERIPH = 2'd1,
      RUN        = 2'd2,
      HOLD       = 2'd3
   } state_t;

   localparam int STB_W = $clog2(STABLE_CYCLES + 1);
   localparam int DLY_W = $clog2(STAGE_DELAY + 1);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);
   localparam logic [STB_W-1:0] STB_ONE  = STB_W'(1);
   localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(STAGE_DELAY - 1);
   localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);
   localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);
   localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
   localparam logic             CALIB_REQ = (REQUIRE_BANK_CALIB != 0);

   logic [SYNC_STAGES-1:0] por_sync_q;
   logic [SYNC_STAGES-1:0] init_sync_q;
   logic [SYNC_STAGES-1:0] calib_sync_q;
   logic [SYNC_STAGES-1:0] pll_sync_q;
   logic                   all_ok_s;

   state_t           state_q, state_d;
   logic [STB_W-1:0] stable_q, stable_d;
   logic [DLY_W-1:0] dly_q, dly_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             fault_q, fault_d;
   logic             periph_q, periph_d;
   logic             cpu_q, cpu_d;

   assign all_ok_s = por_sync_q[SYNC_STAGES-1] & init_sync_q[SYNC_STAGES-1] &
                     pll_sync_q[SYNC_STAGES-1] & (calib_sync_q[SYNC_STAGES-1] | ~CALIB_REQ);

   // Input synchroniser chains, FSM state, counters and registered outputs.
   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         por_sync_q   <= '0;
         init_sync_q  <= '0;
         calib_sync_q <= '0;
         pll_sync_q   <= '0;
         state_q      <= WAIT_READY;
         stable_q     <= '0;
         dly_q        <= '0;
         tmo_q        <= '0;
         fault_q      <= 1'b0;
         periph_q     <= 1'b0;
         cpu_q        <= 1'b0;
      end else begin
         por_sync_q   <= {por_sync_q[SYNC_STAGES-2:0], FABRIC_POR_N};
         init_sync_q  <= {init_sync_q[SYNC_STAGES-2:0], DEVICE_INIT_DONE};
         calib_sync_q <= {calib_sync_q[SYNC_STAGES-2:0], BANK_1_CALIB_STATUS};
         pll_sync_q   <= {pll_sync_q[SYNC_STAGES-2:0], PLL_LOCK};
         state_q      <= state_d;
         stable_q     <= stable_d;
         dly_q        <= dly_d;
         tmo_q        <= tmo_d;
         fault_q      <= fault_d;
         periph_q     <= periph_d;
         cpu_q        <= cpu_d;
      end
   end

   // Next-state logic; counters belonging to other states are held at zero.
   always_comb begin
      state_d  = state_q;
      stable_d = '0;
      dly_d    = '0;
      tmo_d    = '0;
      fault_d  = fault_q;
      case (state_q)
         WAIT_READY: begin
            if (tmo_q == TMO_MAX) begin
               tmo_d = tmo_q;
            end else begin
               tmo_d = tmo_q + TMO_ONE;
            end
            if (tmo_d == TMO_MAX) begin
               fault_d = 1'b1;
            end else begin
               fault_d = fault_q;
            end
            if (!all_ok_s) begin
               stable_d = '0;
            end else if (stable_q == STB_LAST) begin
               state_d = REL_PERIPH;
            end else begin
               stable_d = stable_q + STB_ONE;
            end
         end
         REL_PERIPH: begin
            // Dropout wins over the stage-delay terminal count.
            if (!all_ok_s) begin
               state_d = HOLD;
            end else if (dly_q == DLY_LAST) begin
               state_d = RUN;
            end else begin
               dly_d = dly_q + DLY_ONE;
            end
         end
         RUN: begin
            if (!all_ok_s) begin
               state_d = HOLD;
            end else begin
               state_d = RUN;
            end
         end
         HOLD: begin
            if (dly_q == DLY_LAST) begin
               state_d = WAIT_READY;
            end else begin
               dly_d = dly_q + DLY_ONE;
            end
         end
         default: begin
            state_d = WAIT_READY;
         end
      endcase
      periph_d = (state_d == REL_PERIPH) || (state_d == RUN);
      cpu_d    = (state_d == RUN);
   end

   assign PERIPH_RESET_N = periph_q;
   assign CPU_RESET_N    = cpu_q;
   assign INIT_FAULT     = fault_q;
   assign STATE          = state_q;

endmodule
